// File: rtl/apb_cmd_master_if.sv
// Bundle of the command, response and APB pin groups of apb_cmd_master.
// The master modport is the requester's view; the slave modport is the view
// of whatever sits on the other side (command source, response sink and the
// APB completer), e.g. a testbench.
interface apb_cmd_master_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // command channel
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;

    // response channel
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;

    // APB pins
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  rsp_ready,
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output rsp_ready,
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_cmd_master.sv
// APB command master: buffers read/write commands in a small FIFO, issues
// each one as a complete APB transfer (SETUP then ACCESS until pready or a
// wait timeout) and returns one response per command, strictly in order.
// Only one transfer is ever outstanding, and a new SETUP waits until the
// previous response has been consumed.
module apb_cmd_master #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic             pclk,
    input  logic             preset,
    apb_cmd_master_if.master bus,
    output logic             busy
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // command FIFO storage and bookkeeping
    logic          r_fifo_write [DEPTH];
    logic [AW-1:0] r_fifo_addr  [DEPTH];
    logic [DW-1:0] r_fifo_wdata [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // transfer FSM and registered outputs
    state_t        r_state;
    logic [TW-1:0] r_wait_cnt;
    logic          r_psel;
    logic          r_penable;
    logic          r_pwrite;
    logic [AW-1:0] r_paddr;
    logic [DW-1:0] r_pwdata;
    logic          r_rsp_valid;
    logic [DW-1:0] r_rsp_rdata;
    logic          r_rsp_err;
    logic          r_rsp_timeout;
    logic          r_busy;

    logic          w_full;
    logic          w_empty;
    logic          w_cmd_ready;
    logic          w_push;
    logic          w_pop;
    logic          w_rsp_hs;
    logic [CW-1:0] w_count_nxt;
    logic          w_active_nxt;
    logic          w_busy_nxt;

    // cmd_ready is the only combinational output; it is held low while in
    // reset so nothing is accepted into a FIFO that is being flushed.
    assign w_full      = (r_count == FULL_CNT);
    assign w_empty     = (r_count == {CW{1'b0}});
    assign w_cmd_ready = !w_full && !preset;
    assign w_push      = bus.cmd_valid && w_cmd_ready;
    assign w_pop       = (r_state == ST_IDLE) && !w_empty && !r_rsp_valid;
    assign w_rsp_hs    = r_rsp_valid && bus.rsp_ready;

    assign bus.cmd_ready   = w_cmd_ready;
    assign bus.psel        = r_psel;
    assign bus.penable     = r_penable;
    assign bus.pwrite      = r_pwrite;
    assign bus.paddr       = r_paddr;
    assign bus.pwdata      = r_pwdata;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.rsp_timeout = r_rsp_timeout;
    assign busy            = r_busy;

    // Next FIFO occupancy and whether the FSM will be outside IDLE next cycle.
    always_comb begin
        w_count_nxt  = r_count;
        w_active_nxt = 1'b0;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + {{(CW-1){1'b0}}, 1'b1};
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            w_count_nxt = r_count;
        end
        case (r_state)
            ST_IDLE:   w_active_nxt = w_pop;
            ST_SETUP:  w_active_nxt = 1'b1;
            ST_ACCESS: w_active_nxt = 1'b1;
            ST_RESP:   w_active_nxt = !w_rsp_hs;
            default:   w_active_nxt = 1'b0;
        endcase
        w_busy_nxt = (w_count_nxt != {CW{1'b0}}) || w_active_nxt;
    end

    // Capture accepted commands into the slot at the write pointer.
    always_ff @(posedge pclk) begin
        if (w_push) begin
            r_fifo_write[r_wr_ptr] <= bus.cmd_write;
            r_fifo_addr[r_wr_ptr]  <= bus.cmd_addr;
            r_fifo_wdata[r_wr_ptr] <= bus.cmd_wdata;
        end
    end

    // FIFO pointers and count; pointers wrap naturally since DEPTH is 2^PW.
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
            r_busy   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + {{(PW-1){1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{(PW-1){1'b0}}, 1'b1};
            end
            r_count <= w_count_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Transfer FSM: sequences SETUP/ACCESS on the APB pins and owns the response.
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state       <= ST_IDLE;
            r_wait_cnt    <= {TW{1'b0}};
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= {AW{1'b0}};
            r_pwdata      <= {DW{1'b0}};
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= {DW{1'b0}};
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_pwrite  <= r_fifo_write[r_rd_ptr];
                        r_paddr   <= r_fifo_addr[r_rd_ptr];
                        r_pwdata  <= r_fifo_wdata[r_rd_ptr];
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_state   <= ST_SETUP;
                    end else begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    // pready is deliberately not looked at here
                    r_penable  <= 1'b1;
                    r_wait_cnt <= {TW{1'b0}};
                    r_state    <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (bus.pready) begin
                        r_rsp_rdata   <= (!r_pwrite && !bus.pslverr) ? bus.prdata : {DW{1'b0}};
                        r_rsp_err     <= bus.pslverr;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_state       <= ST_RESP;
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        // completer never answered: abort and report
                        r_rsp_rdata   <= {DW{1'b0}};
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_state       <= ST_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + {{(TW-1){1'b0}}, 1'b1};
                    end
                end
                ST_RESP: begin
                    if (w_rsp_hs) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_psel      <= 1'b0;
                    r_penable   <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master. A behavioural APB RAM (32 words,
// pslverr above that, configurable wait states or never-ready) sits on the
// APB side. Expected responses come from a reference model: a word array
// plus a queue of responses computed when each command is accepted.
module tb_apb_cmd_master;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } exp_t;

    logic pclk;
    logic preset;
    logic busy;

    apb_cmd_master_if #(.AW(AW), .DW(DW)) bus ();

    apb_cmd_master #(.AW(AW), .DW(DW), .DEPTH(4), .TIMEOUT(16)) dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus),
        .busy   (busy)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int checks   = 0;
    int failures = 0;

    // reference model
    logic [31:0] mdl_mem [32];
    exp_t        exp_q [$];

    // monitor bookkeeping (written only by the main initial block)
    int cyc;
    int psel_cycles;
    bit prev_psel;
    bit prev_rv;
    int psel_rise [$];
    int rv_rise [$];

    // APB RAM completer
    logic [31:0] slv_mem [32];
    bit          slv_inited;
    int          slv_cnt;
    int          slv_wait;
    bit          slv_never;

    always @(posedge pclk) begin
        if (preset) begin
            bus.pready  <= 1'b0;
            bus.pslverr <= 1'b0;
            bus.prdata  <= 32'h0;
            slv_cnt     <= 0;
            if (!slv_inited) begin
                for (int i = 0; i < 32; i++) slv_mem[i] <= 32'h0;
                slv_inited <= 1'b1;
            end
        end else if (bus.psel && bus.penable && !bus.pready) begin
            if (slv_never) begin
                bus.pslverr <= 1'b1;
                bus.prdata  <= $urandom;
            end else if (slv_cnt >= slv_wait) begin
                bus.pready <= 1'b1;
                slv_cnt    <= 0;
                if (bus.paddr < 32'd32) begin
                    bus.pslverr <= 1'b0;
                    if (bus.pwrite) begin
                        slv_mem[bus.paddr[4:0]] <= bus.pwdata;
                        bus.prdata <= $urandom;
                    end else begin
                        bus.prdata <= slv_mem[bus.paddr[4:0]];
                    end
                end else begin
                    bus.pslverr <= 1'b1;
                    bus.prdata  <= $urandom;
                end
            end else begin
                slv_cnt     <= slv_cnt + 1;
                bus.pslverr <= 1'($urandom_range(0, 1));
                bus.prdata  <= $urandom;
            end
        end else begin
            bus.pready  <= 1'b0;
            bus.pslverr <= 1'b0;
            slv_cnt     <= 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // expected response of one accepted command, from the RAM rules
    task automatic model_push(input logic w, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        if (slv_never) begin
            e = '{rdata: 32'h0, err: 1'b1, to: 1'b1};
        end else if (a >= 32'd32) begin
            e = '{rdata: 32'h0, err: 1'b1, to: 1'b0};
        end else if (w) begin
            mdl_mem[a[4:0]] = d;
            e = '{rdata: 32'h0, err: 1'b0, to: 1'b0};
        end else begin
            e = '{rdata: mdl_mem[a[4:0]], err: 1'b0, to: 1'b0};
        end
        exp_q.push_back(e);
    endtask

    // advance to the next falling edge; checks any response consumed at the rising edge
    task automatic tick();
        logic        hs;
        logic [31:0] rd;
        logic        er;
        logic        to;
        exp_t        e;
        hs = bus.rsp_valid && bus.rsp_ready;
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        to = bus.rsp_timeout;
        @(negedge pclk);
        cyc++;
        if (bus.psel === 1'b1) psel_cycles++;
        if (bus.psel === 1'b1 && !prev_psel) psel_rise.push_back(cyc);
        if (bus.rsp_valid === 1'b1 && !prev_rv) rv_rise.push_back(cyc);
        prev_psel = (bus.psel === 1'b1);
        prev_rv   = (bus.rsp_valid === 1'b1);
        if (hs === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_rdata", 64'(rd), 64'(e.rdata));
                chk("rsp_err", 64'(er), 64'(e.err));
                chk("rsp_timeout", 64'(to), 64'(e.to));
            end
        end
    endtask

    task automatic push_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        #1;
        while (!acc && n < 100) begin
            acc = (bus.cmd_ready === 1'b1);
            tick();
            n++;
        end
        chk("cmd_accept", 64'(acc), 64'd1);
        if (acc) model_push(w, a, d);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drain_all(input bit rnd);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            bus.rsp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        chk("drain_done", 64'(exp_q.size()), 64'd0);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acc_cnt;
        int r0, r1, r2, v0;
        for (int i = 0; i < 32; i++) mdl_mem[i] = 32'h0;
        preset        = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h0;
        bus.cmd_wdata = 32'h0;
        bus.rsp_ready = 1'b0;
        slv_wait      = 0;
        slv_never     = 1'b0;

        // ---- reset state
        @(negedge pclk);
        tick();
        tick();
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        chk("rst_psel", 64'(bus.psel), 64'd0);
        chk("rst_penable", 64'(bus.penable), 64'd0);
        chk("rst_pwrite", 64'(bus.pwrite), 64'd0);
        chk("rst_paddr", 64'(bus.paddr), 64'd0);
        chk("rst_pwdata", 64'(bus.pwdata), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        chk("rst_rsp_timeout", 64'(bus.rsp_timeout), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        preset = 1'b0;
        #1;
        chk("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);

        // ---- write 0xDEADBEEF to addr 5, cycle by cycle
        push_cmd(1'b1, 32'd5, 32'hDEADBEEF);
        chk("w5_idle_psel", 64'(bus.psel), 64'd0);
        chk("w5_busy", 64'(busy), 64'd1);
        tick();
        chk("w5_setup_psel", 64'(bus.psel), 64'd1);
        chk("w5_setup_penable", 64'(bus.penable), 64'd0);
        chk("w5_paddr", 64'(bus.paddr), 64'd5);
        chk("w5_pwrite", 64'(bus.pwrite), 64'd1);
        chk("w5_pwdata", 64'(bus.pwdata), 64'hDEADBEEF);
        tick();
        chk("w5_acc1_psel", 64'(bus.psel), 64'd1);
        chk("w5_acc1_penable", 64'(bus.penable), 64'd1);
        tick();
        chk("w5_acc2_penable", 64'(bus.penable), 64'd1);
        chk("w5_acc2_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        tick();
        chk("w5_resp_psel", 64'(bus.psel), 64'd0);
        chk("w5_resp_penable", 64'(bus.penable), 64'd0);
        chk("w5_resp_valid", 64'(bus.rsp_valid), 64'd1);
        tick();
        chk("w5_held_valid", 64'(bus.rsp_valid), 64'd1);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("w5_valid_cleared", 64'(bus.rsp_valid), 64'd0);
        chk("w5_busy_cleared", 64'(busy), 64'd0);
        chk("w5_queue_empty", 64'(exp_q.size()), 64'd0);

        // ---- read back, write/read addr 31, out-of-range read
        push_cmd(1'b0, 32'd5, 32'h0);
        drain_all(1'b0);
        push_cmd(1'b1, 32'd31, 32'h1);
        push_cmd(1'b0, 32'd31, 32'h0);
        push_cmd(1'b0, 32'd40, 32'h0);
        drain_all(1'b0);

        // ---- timeout with pready never returned
        slv_never = 1'b1;
        push_cmd(1'b0, 32'd3, 32'h0);
        n = 0;
        while (!(bus.psel === 1'b1 && bus.penable === 1'b1) && n < 50) begin
            tick();
            n++;
        end
        acc_cnt = 0;
        while (bus.psel === 1'b1 && bus.penable === 1'b1 && acc_cnt < 100) begin
            acc_cnt++;
            tick();
        end
        chk("to_access_cycles", 64'(acc_cnt), 64'd16);
        chk("to_psel_dropped", 64'(bus.psel), 64'd0);
        chk("to_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        drain_all(1'b0);
        slv_never = 1'b0;

        // ---- FIFO full with responses stalled
        psel_cycles = 0;
        for (int k = 0; k < 5; k++) push_cmd(1'b1, 32'(10 + k), 32'(32'hA000 + k));
        chk("full_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'd11;
        for (int k = 0; k < 20; k++) tick();
        bus.cmd_valid = 1'b0;
        chk("full_still_not_ready", 64'(bus.cmd_ready), 64'd0);
        chk("full_single_transfer", 64'(psel_cycles), 64'd3);
        chk("full_rsp_pending", 64'(bus.rsp_valid), 64'd1);
        chk("full_busy", 64'(busy), 64'd1);
        drain_all(1'b0);
        push_cmd(1'b0, 32'd12, 32'h0);
        drain_all(1'b0);

        // ---- back-to-back spacing with rsp_ready held high
        bus.rsp_ready = 1'b1;
        psel_rise.delete();
        rv_rise.delete();
        push_cmd(1'b1, 32'd20, 32'h1111);
        push_cmd(1'b1, 32'd21, 32'h2222);
        push_cmd(1'b0, 32'd20, 32'h0);
        drain_all(1'b0);
        for (int k = 0; k < 3; k++) tick();
        chk("b2b_transfers", 64'(psel_rise.size()), 64'd3);
        r0 = (psel_rise.size() > 0) ? psel_rise[0] : 0;
        r1 = (psel_rise.size() > 1) ? psel_rise[1] : 0;
        r2 = (psel_rise.size() > 2) ? psel_rise[2] : 0;
        v0 = (rv_rise.size() > 0) ? rv_rise[0] : 0;
        chk("b2b_gap1", 64'(r1 - r0), 64'd5);
        chk("b2b_gap2", 64'(r2 - r1), 64'd5);
        chk("b2b_rv_to_psel", 64'(r1 - v0), 64'd2);
        chk("b2b_rv_latency", 64'(v0 - r0), 64'd3);

        // ---- reset in the middle of ACCESS
        slv_wait = 6;
        push_cmd(1'b0, 32'd5, 32'h0);
        n = 0;
        while (!(bus.psel === 1'b1 && bus.penable === 1'b1) && n < 50) begin
            tick();
            n++;
        end
        tick();
        preset = 1'b1;
        tick();
        chk("mrst_psel", 64'(bus.psel), 64'd0);
        chk("mrst_penable", 64'(bus.penable), 64'd0);
        chk("mrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        preset = 1'b0;
        exp_q.delete();
        slv_wait = 0;
        #1;
        chk("mrst_cmd_ready_after", 64'(bus.cmd_ready), 64'd1);
        bus.rsp_ready = 1'b1;
        psel_cycles = 0;
        for (int k = 0; k < 12; k++) tick();
        bus.rsp_ready = 1'b0;
        chk("mrst_no_transfer", 64'(psel_cycles), 64'd0);
        chk("mrst_busy_idle", 64'(busy), 64'd0);
        push_cmd(1'b1, 32'd7, 32'h77);
        push_cmd(1'b0, 32'd7, 32'h0);
        drain_all(1'b0);

        // ---- randomized traffic
        for (int it = 0; it < 25; it++) begin
            slv_wait = $urandom_range(0, 2);
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                push_cmd(1'($urandom_range(0, 1)), 32'($urandom_range(0, 39)), $urandom);
            end
            drain_all(1'b1);
        end
        chk("end_busy", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
